// File: rtl/alu_pkg.sv
// Shared decode definitions for the R-type issue path: opcode/funct codes,
// instruction field positions and the decoded-instruction payload.
package alu_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned FUNCT_W  = 6;

    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNCT_LSB  = 0;

    localparam logic [OPCODE_W-1:0] OPCODE_RTYPE = 6'b000000;
    localparam logic [FUNCT_W-1:0]  FUNCT_ADD    = 6'b100000;
    localparam logic [FUNCT_W-1:0]  FUNCT_SUB    = 6'b100010;
    localparam logic [FUNCT_W-1:0]  FUNCT_SRL    = 6'b000010;

    typedef struct packed {
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  rd;
        logic [SHAMT_W-1:0] shamt;
        logic [FUNCT_W-1:0] funct;
        logic               legal;
    } decoded_instr_t;

    // Field split plus legality: only R-type add/sub/srl are supported.
    function automatic decoded_instr_t decode_instr(input logic [INSTR_W-1:0] instr);
        decoded_instr_t      d;
        logic [OPCODE_W-1:0] opcode;
        opcode  = instr[OPCODE_LSB +: OPCODE_W];
        d.rs    = instr[RS_LSB +: REG_AW];
        d.rt    = instr[RT_LSB +: REG_AW];
        d.rd    = instr[RD_LSB +: REG_AW];
        d.shamt = instr[SHAMT_LSB +: SHAMT_W];
        d.funct = instr[FUNCT_LSB +: FUNCT_W];
        d.legal = (opcode == OPCODE_RTYPE) &&
                  ((d.funct == FUNCT_ADD) || (d.funct == FUNCT_SUB) || (d.funct == FUNCT_SRL));
        return d;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register array with two asynchronous read ports and one synchronous write port.
// Entry 0 always reads as zero and ignores writes.
module regfile_2r1w
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// Issue/read stage: decodes R-type words, reads operands with write-back bypass,
// tracks in-flight destinations in a scoreboard and stalls on read-after-write hazards.
module operand_fetch
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  op_a,
    output logic [DATA_W-1:0]  op_b,
    output logic [SHAMT_W-1:0] shamt_o,
    output logic [FUNCT_W-1:0] funct_o,
    output logic [REG_AW-1:0]  rd_o,
    output logic               illegal
);

    decoded_instr_t    dec;
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_next;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              byp_a;
    logic              byp_b;
    logic              hazard;
    logic              accept;

    assign dec = decode_instr(instr);

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (dec.rs),
        .raddr_b (dec.rt),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // A write-back landing this cycle both bypasses the operand and resolves its hazard.
    always_comb begin
        byp_a  = wb_en && (wb_rd == dec.rs) && (dec.rs != '0);
        byp_b  = wb_en && (wb_rd == dec.rt) && (dec.rt != '0);
        hazard = ((dec.rs != '0) && pending[dec.rs] && !byp_a) ||
                 ((dec.rt != '0) && pending[dec.rt] && !byp_b);
        in_ready = !hazard && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        opnd_a   = byp_a ? wb_data : rdata_a;
        opnd_b   = byp_b ? wb_data : rdata_b;
    end

    // Setting a destination outranks a same-cycle clear of the same register.
    always_comb begin
        pending_next = pending;
        if (wb_en) begin
            pending_next[wb_rd] = 1'b0;
        end
        if (accept && dec.legal && (dec.rd != '0)) begin
            pending_next[dec.rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            out_valid <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            shamt_o   <= '0;
            funct_o   <= '0;
            rd_o      <= '0;
            illegal   <= 1'b0;
        end else begin
            pending <= pending_next;
            if (accept) begin
                out_valid <= 1'b1;
                op_a      <= opnd_a;
                op_b      <= opnd_b;
                shamt_o   <= dec.shamt;
                funct_o   <= dec.funct;
                rd_o      <= dec.rd;
                illegal   <= !dec.legal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table for the hazard,
// back-pressure, illegal and reset scenarios, then randomized traffic against a model.
module tb_operand_fetch;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] SRL = 6'b000010;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt_o;
    logic [5:0]  funct_o;
    logic [4:0]  rd_o;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt_o   (shamt_o),
        .funct_o   (funct_o),
        .rd_o      (rd_o),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Reference state: architectural registers, in-flight destinations, output bundle.
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_valid;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_sh, m_rd;
    logic [5:0]  m_fn;
    bit          m_ill;
    bit          m_ready;
    logic        act_ready;

    typedef struct {
        bit          rst;
        bit          iv;
        logic [31:0] ins;
        bit          wbe;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        bit          ordy;
        bit          chk_rdy;
        bit          e_rdy;
        bit          e_val;
        bit          chk_f;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [4:0]  e_sh;
        logic [5:0]  e_fn;
        logic [4:0]  e_rd;
        bit          e_ill;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    function automatic vec_t v(input bit r, input bit iv, input logic [31:0] ins,
                               input bit wbe, input logic [4:0] wbrd, input logic [31:0] wbd,
                               input bit ordy, input bit chk_rdy, input bit e_rdy,
                               input bit e_val, input bit chk_f, input logic [31:0] e_a,
                               input logic [31:0] e_b, input logic [4:0] e_sh,
                               input logic [5:0] e_fn, input logic [4:0] e_rd, input bit e_ill);
        vec_t x;
        x.rst = r; x.iv = iv; x.ins = ins; x.wbe = wbe; x.wbrd = wbrd; x.wbd = wbd;
        x.ordy = ordy; x.chk_rdy = chk_rdy; x.e_rdy = e_rdy; x.e_val = e_val;
        x.chk_f = chk_f; x.e_a = e_a; x.e_b = e_b; x.e_sh = e_sh; x.e_fn = e_fn;
        x.e_rd = e_rd; x.e_ill = e_ill;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit blocked(input logic [4:0] r, input bit wbe, input logic [4:0] wbrd);
        return (r != 0) && m_pend[r] && !(wbe && (wbrd == r));
    endfunction

    function automatic logic [31:0] read_opnd(input logic [4:0] r, input bit wbe,
                                              input logic [4:0] wbrd, input logic [31:0] wbd);
        if (r == 0) return 32'h0;
        if (wbe && (wbrd == r)) return wbd;
        return m_regs[r];
    endfunction

    // One clock: drive, sample in_ready mid-cycle, advance the model across the edge.
    task automatic cycle(input bit r, input bit iv, input logic [31:0] ins, input bit wbe,
                         input logic [4:0] wbrd, input logic [31:0] wbd, input bit ordy);
        logic [4:0] rs, rt, rd;
        logic [5:0] op, fn;
        bit         legal, acc;
        rst = r; in_valid = iv; instr = ins; wb_en = wbe; wb_rd = wbrd; wb_data = wbd;
        out_ready = ordy;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
        legal = (op == 6'd0) && (fn == ADD || fn == SUB || fn == SRL);
        #1;
        act_ready = in_ready;
        m_ready = !blocked(rs, wbe, wbrd) && !blocked(rt, wbe, wbrd) && (!m_valid || ordy);
        acc = iv && m_ready && !r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_pend[i] = 1'b0;
            end
            m_valid = 0; m_a = 0; m_b = 0; m_sh = 0; m_fn = 0; m_rd = 0; m_ill = 0;
        end else begin
            if (acc) begin
                m_valid = 1;
                m_a = read_opnd(rs, wbe, wbrd, wbd);
                m_b = read_opnd(rt, wbe, wbrd, wbd);
                m_sh = ins[10:6]; m_fn = fn; m_rd = rd; m_ill = !legal;
            end else if (ordy) begin
                m_valid = 0;
            end
            if (wbe) m_pend[wbrd] = 1'b0;
            if (acc && legal && rd != 0) m_pend[rd] = 1'b1;
            if (wbe && wbrd != 0) m_regs[wbrd] = wbd;
        end
        #1;
    endtask

    initial begin
        rst = 1; in_valid = 0; instr = 0; wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 1;

        vecs.push_back(v(1,0,0,0,0,0,1, 0,0, 0,1, 0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,5,32'hAA,1, 1,1, 0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,1,ri(0,5,0,3,0,ADD),0,0,0,1, 1,1, 1,1, 32'hAA,0,0,ADD,3,0));
        vecs.push_back(v(0,0,0,1,3,32'hAB,1, 1,1, 0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,1,32'h1,1, 1,1, 0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,2,32'h2,1, 1,1, 0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,1,ri(0,1,2,4,0,ADD),0,0,0,1, 1,1, 1,1, 1,2,0,ADD,4,0));
        vecs.push_back(v(0,1,ri(0,4,1,6,0,SUB),0,0,0,1, 1,0, 0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,1,ri(0,4,1,6,0,SUB),0,0,0,1, 1,0, 0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,1,ri(0,4,1,6,0,SUB),1,4,32'h3,1, 1,1, 1,1, 3,1,0,SUB,6,0));
        vecs.push_back(v(0,0,0,1,6,32'h2,1, 1,1, 0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,1,ri(0,1,2,8,0,ADD),0,0,0,1, 1,1, 1,1, 1,2,0,ADD,8,0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(v(0,1,ri(0,2,1,9,0,SUB),0,0,0,0, 1,0, 1,1, 1,2,0,ADD,8,0));
        vecs.push_back(v(0,1,ri(0,2,1,9,0,SUB),0,0,0,1, 1,1, 1,1, 2,1,0,SUB,9,0));
        vecs.push_back(v(0,0,0,1,8,32'h3,1, 1,1, 0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,9,32'h1,1, 1,1, 0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,1,ri(6'h08,1,2,10,0,ADD),0,0,0,1, 1,1, 1,1, 1,2,0,ADD,10,1));
        vecs.push_back(v(0,1,ri(0,1,2,11,0,6'h00),0,0,0,1, 1,1, 1,1, 1,2,0,6'h00,11,1));
        vecs.push_back(v(0,1,ri(0,10,11,12,0,ADD),0,0,0,1, 1,1, 1,1, 0,0,0,ADD,12,0));
        vecs.push_back(v(0,0,0,1,12,32'h0,1, 1,1, 0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,0,0,1,0,32'hFFFF_FFFF,1, 1,1, 0,0, 0,0,0,0,0,0));
        vecs.push_back(v(0,1,ri(0,0,0,7,4,SRL),0,0,0,1, 1,1, 1,1, 0,0,4,SRL,7,0));
        vecs.push_back(v(0,1,ri(0,1,2,9,0,ADD),0,0,0,1, 1,1, 1,1, 1,2,0,ADD,9,0));
        vecs.push_back(v(1,0,0,1,9,32'h55,1, 0,0, 0,1, 0,0,0,0,0,0));
        vecs.push_back(v(0,1,ri(0,9,9,13,0,ADD),0,0,0,1, 1,1, 1,1, 0,0,0,ADD,13,0));

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].iv, vecs[i].ins, vecs[i].wbe, vecs[i].wbrd,
                  vecs[i].wbd, vecs[i].ordy);
            if (vecs[i].chk_rdy) chk($sformatf("vec%0d in_ready", i), 32'(act_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_val));
            if (vecs[i].chk_f) begin
                chk($sformatf("vec%0d op_a", i), op_a, vecs[i].e_a);
                chk($sformatf("vec%0d op_b", i), op_b, vecs[i].e_b);
                chk($sformatf("vec%0d shamt_o", i), 32'(shamt_o), 32'(vecs[i].e_sh));
                chk($sformatf("vec%0d funct_o", i), 32'(funct_o), 32'(vecs[i].e_fn));
                chk($sformatf("vec%0d rd_o", i), 32'(rd_o), 32'(vecs[i].e_rd));
                chk($sformatf("vec%0d illegal", i), 32'(illegal), 32'(vecs[i].e_ill));
            end
        end

        // Randomized traffic over a small register window to provoke frequent hazards.
        cycle(1, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            bit          r, iv, wbe, ordy;
            logic [5:0]  op, fn;
            logic [31:0] ins;
            r    = ($urandom_range(0, 99) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            wbe  = ($urandom_range(0, 9) < 4);
            ordy = ($urandom_range(0, 3) != 0);
            op   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'd0;
            case ($urandom_range(0, 3))
                0: fn = ADD;
                1: fn = SUB;
                2: fn = SRL;
                default: fn = 6'($urandom);
            endcase
            ins = ri(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom), fn);
            cycle(r, iv, ins, wbe, 5'($urandom_range(0, 7)), $urandom, ordy);
            if (!r) chk("rnd in_ready", 32'(act_ready), 32'(m_ready));
            chk("rnd out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid || r) begin
                chk("rnd op_a", op_a, m_a);
                chk("rnd op_b", op_b, m_b);
                chk("rnd shamt_o", 32'(shamt_o), 32'(m_sh));
                chk("rnd funct_o", 32'(funct_o), 32'(m_fn));
                chk("rnd rd_o", 32'(rd_o), 32'(m_rd));
                chk("rnd illegal", 32'(illegal), 32'(m_ill));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue/read stage feeding the ALU result mux. Accepts 32-bit R-type instruction words, decodes rs/rt/rd/shamt/funct, reads two operands from the register file it owns, and presents them to the ALU with a valid/ready handshake. Accepts the ALU write-back, which it bypasses to operand reads and uses to clear a per-register scoreboard. Read-after-write hazards stall issue.

## Interface
- DATA_W, 32, operand and register width
- NREGS, 32, register count; address width is 5
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage accepts instruction this cycle
- instr  in  32  instruction: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct
- wb_en  in  1  write-back strobe from result mux
- wb_rd  in  5  write-back destination
- wb_data  in  DATA_W  write-back value
- out_valid  out  1  operand bundle valid
- out_ready  in  1  ALU consumes bundle
- op_a  out  DATA_W  value of reg[rs]
- op_b  out  DATA_W  value of reg[rt]
- shamt_o  out  5  shift amount
- funct_o  out  6  function code
- rd_o  out  5  destination register
- illegal  out  1  bundle is not a supported R-type op

## Operation
- Register file: NREGS x DATA_W, r0 reads 0, writes to r0 ignored; write on wb_en at clk edge.
- Scoreboard: pending[NREGS] bits, pending[0] always 0.
- Hazard: rs!=0 && pending[rs] && !(wb_en && wb_rd==rs); same for rt. Write-back in the same cycle satisfies the hazard.
- in_ready = !hazard && (!out_valid || out_ready). Combinational from instr, wb_*, out_ready.
- Accept (in_valid && in_ready): load output register. op_a/op_b use wb_data when wb_en && wb_rd==rs/rt (nonzero), else the array. Set out_valid.
- Decode: legal iff opcode==0 and funct in {100000 add, 100010 sub, 000010 srl}. Illegal bundles pass with illegal=1 and do not set pending.
- On legal accept with rd!=0: set pending[rd].
- On wb_en: clear pending[wb_rd]. If the same cycle sets pending for the same register, the set wins.
- out_valid && !out_ready: all outputs held stable. Consume without a new accept clears out_valid.

## Timing
- Reset: out_valid=0, illegal=0, op_a=op_b=0, shamt_o=funct_o=rd_o=0, all registers 0, pending all 0. in_ready=1 the cycle after rst deasserts.
- Reset mid-operation discards the held bundle and all pending bits. Write-back in the reset cycle is dropped.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 bundle/cycle with out_ready held high.
- Dependent pair: consumer stalls until the producer's write-back cycle and is accepted in that same cycle via bypass.
- A register write at edge N is visible to array reads from cycle N+1. The same-cycle value comes only through the bypass.

## Structure
- Shared package alu_pkg holds:
  - OPCODE_RTYPE, FUNCT_ADD, FUNCT_SUB, FUNCT_SRL
  - instr field position constants
  - decoded_instr_t struct {rs, rt, rd, shamt, funct, legal}
- Sub-module regfile_2r1w holds the array:
  - two asynchronous read ports, one write port
  - r0 hardwired to 0, synchronous reset to zero
- Scoreboard, bypass and handshake logic stay in operand_fetch.

## Test plan
- Reset, then wb r5=0x0000_00AA, then issue add rd=3 rs=5 rt=0 → op_a=0xAA, op_b=0, funct_o=100000, rd_o=3, out_valid one cycle after accept.
- Issue add rd=4 (r1=1, r2=2), then sub rd=6 rs=4 rt=1 → in_ready=0 until wb r4=3 is presented. Accept in that cycle with op_a=3 via bypass, op_b=1.
- Hold out_ready=0 for 4 cycles with a valid bundle → outputs unchanged. in_ready=0 for a second instruction. Raise out_ready → both drain back-to-back.
- Issue opcode 0x08 or funct 000000 → illegal=1, pending unchanged. Next instruction reading that rd is not stalled.
- wb r0=0xFFFF_FFFF, then issue srl rd=7 rs=0 rt=0 shamt=4 → op_a=op_b=0, shamt_o=4.
- Assert rst while r9 is pending and out_valid=1 → next cycle out_valid=0. An instruction reading r9 is accepted immediately with op_a=0.
